// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath blocks:
// divider state encoding, default operand width and counter sizing.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_in[WIDTH-1:0], bit_in};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};

  // A set top bit means the shifted value is already beyond any WIDTH-bit divisor.
  assign q_bit   = rem_in[WIDTH] | ~trial[WIDTH+1];
  assign rem_out = q_bit ? trial[WIDTH:0] : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/done handshake, results held until the next accepted start.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] shift_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_reg),
    .bit_in (shift_reg[WIDTH-1]),
    .divisor(divisor_reg),
    .rem_out(rem_next),
    .q_bit  (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign shift_next = {shift_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg   <= dividend;
            divisor_reg <= divisor;
            rem_reg     <= '0;
            cnt_reg     <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Division by zero resolves without iterating.
              state_reg   <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy      <= 1'b1;
            end
          end
        end

        RUN: begin
          shift_reg <= shift_next;
          rem_reg   <= rem_next;
          cnt_reg   <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= shift_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end

        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse of the team's combinational 4x4 array multiplier.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/done handshake and sits beside the multiplier in the arithmetic datapath.
- Round-trip property: for divisor != 0, quotient*divisor + remainder == dividend; the multiplier product of quotient and divisor, plus remainder, reproduces the dividend.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal: 2..16).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- dividend, input, WIDTH, numerator; captured on accepted start.
- divisor, input, WIDTH, denominator; captured on accepted start.
- busy, output, 1, high while a division is in progress (RUN).
- done, output, 1, one-cycle pulse when results become valid.
- quotient, output, WIDTH, result; held until the next accepted start.
- remainder, output, WIDTH, result; held until the next accepted start.
- div_by_zero, output, 1, set with done when divisor was 0; held with results.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Capture dividend into the quotient/shift register and divisor into a register.
  - Clear the partial remainder (WIDTH+1 bits) and load the iteration counter with WIDTH.
  - If captured divisor==0, go to DONE. Otherwise go to RUN with busy=1.
- IDLE, start=0: no state change; outputs hold.
- RUN, one step per edge:
  - Form {rem, q_msb}, trial = that value - divisor.
  - If trial is non-negative, rem=trial and shift in 1; otherwise rem keeps the shifted value and shift in 0.
  - Counter decrements. When the counter reaches 0 after the WIDTH-th step, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - quotient and remainder registers present final values.
  - Unconditionally return to IDLE next edge.
- Latency:
  - divisor!=0: start edge to done-high cycle = WIDTH+1 edges (WIDTH=4: done visible 5 cycles after start is sampled).
  - divisor==0: done-high cycle 1 edge after start.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- div_by_zero is cleared on the next accepted start.
- start while busy or in DONE is ignored. Its operands are not captured and it is not queued.
- start held high continuously: a new division is accepted on each return to IDLE. Period is WIDTH+2 cycles.
- Operand inputs may change freely after acceptance without affecting the result.
- quotient/remainder outputs:
  - Update only when DONE is entered; no intermediate values are visible.
  - Inside the datapath, the shift register is separate from the output registers.
- Reset mid-RUN: immediate abort to IDLE; all outputs cleared; no done pulse.
- Arithmetic is unsigned throughout. The partial remainder carries one extra bit so the trial subtract never overflows. Results are always < 2^WIDTH.

Decomposition:
- Shared package arith_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - Counter width function, ceil log2 of (WIDTH+1).
- One natural sub-module div_step, purely combinational:
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next remainder and quotient bit.
- The FSM, counter and registers stay in seq_divider.

Test Plan:
- Reset, then dividend=13, divisor=3, start pulse -> busy for 4 cycles; done pulse on 5th cycle; quotient=4, remainder=1, div_by_zero=0.
- Corner values:
  - 15/1 -> quotient=15, remainder=0.
  - 2/9 -> quotient=0, remainder=2.
  - 15/15 -> quotient=1, remainder=0.
- dividend=7, divisor=0 -> done 1 cycle after start; quotient=15, remainder=7, div_by_zero=1. Next valid division (6/2) clears the flag and gives quotient=3, remainder=0.
- 12/5 in flight; start with 9/3 asserted during RUN -> ignored; result quotient=2, remainder=2; only one done pulse.
- rst_n pulsed low mid-RUN of 11/2 -> outputs immediately 0, no done. After release, 11/2 -> quotient=5, remainder=1.
- Exhaustive all 256 operand pairs with start held high:
  - For divisor!=0, check quotient*divisor+remainder==dividend and remainder<divisor.
  - Check the done period is 6 cycles (WIDTH=4).
